fetch_pc: RTL and testbench
===========================

FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter EXC_ENTRY, default 32'h0000_4180, meaning the exception/interrupt handler entry.
REQ-003 SHALL have parameter HALT_PC, default 32'h0000_417C (kernel text start minus 4), meaning the self-loop terminate address.
REQ-004 SHALL have ports as follows; one clock; reset is synchronous and active-high:
  clk  in  1  sole clock, rising edge
  reset  in  1  synchronous, active-high
  stall  in  1  hazard-unit hold of IF
  npc  in  32  next PC from next-PC calculator
  isBJ  in  1  instruction now in ID is branch/jump (next fetch is its delay slot)
  excReq  in  1  CP0 exception/interrupt redirect request
  eretReq  in  1  CP0 ERET redirect request
  epc  in  32  ERET return address
  PC  out  32  current fetch address to instruction memory
  pcValid  out  1  PC holds a fetch to be issued
  bd  out  1  fetch at PC is a branch delay slot
  halted  out  1  fetch has reached HALT_PC
  adel  out  1  fetch address error (see Configuration)
  excCode  out  5  5'd4 when adel, else 5'd0
  fetchCnt  out  32  count of fetches issued

Function
REQ-005 SHALL implement states BOOT, RUN, HALT; reset enters BOOT.
REQ-006 BOOT SHALL last exactly one cycle: PC=RESET_PC, pcValid=0, no advance; next state RUN.
REQ-007 In RUN/HALT, next-PC priority SHALL be: excReq > eretReq > stall > HALT hold > npc.
REQ-008 excReq SHALL load EXC_ENTRY on the next edge, clear bd, enter RUN, even during stall or HALT.
REQ-009 eretReq (excReq low) SHALL load epc on the next edge, clear bd, enter RUN, even during stall or HALT.
REQ-010 stall (no redirect) SHALL hold PC, bd, state and fetchCnt.
REQ-011 No stall/redirect in RUN: PC<=npc, bd<=isBJ on the edge.
REQ-012 When PC==HALT_PC in RUN, state SHALL become HALT on the next edge; halted=1 while in HALT; PC holds regardless of npc.
REQ-013 pcValid SHALL be 1 in RUN and HALT except when adel=1.
REQ-014 fetchCnt SHALL increment by 1 on every edge where pcValid=1, stall=0, state!=HALT; wraps 32'hFFFF_FFFF -> 0.
REQ-015 PC SHALL be registered; outputs SHALL be valid from the cycle after the edge, no combinational path from npc to PC.
REQ-016 excReq and eretReq high together SHALL act as excReq alone.

Reset
REQ-017 On reset edge: PC=RESET_PC, state=BOOT, pcValid=0, bd=0, halted=0, adel=0, excCode=0, fetchCnt=0.
REQ-018 reset SHALL override stall, excReq and eretReq in the same cycle; reset mid-HALT or mid-stall returns to BOOT.

Configuration
REQ-019 Macro FETCH_ADEL_CHECK_EN SHALL gate fetch address checking.
REQ-020 With FETCH_ADEL_CHECK_EN defined: adel=1 combinationally when PC[1:0]!=0 or PC outside [32'h3000, 32'h6FFC], state!=BOOT; then excCode=5'd4, pcValid=0, fetchCnt not incremented; PC still follows REQ-007.
REQ-021 Without FETCH_ADEL_CHECK_EN: adel tied 0, excCode tied 0, no checking logic.

Verification
REQ-022 Reset 1 cycle, then idle with npc=PC+4 -> BOOT cycle PC=0x3000 pcValid=0; then 0x3000, 0x3004, 0x3008 with pcValid=1, fetchCnt 0,1,2.
REQ-023 At PC=0x3010, isBJ=1, npc=0x3040 -> next PC=0x3040, bd=1; following npc=0x3044, isBJ=0 -> bd=0.
REQ-024 stall=1 for 3 cycles at PC=0x3020 -> PC, bd, fetchCnt unchanged; excReq during stall -> PC=0x4180, bd=0.
REQ-025 Drive npc to 0x417C -> PC=0x417C, next edge halted=1, PC stays 0x417C with npc=0x4180; then eretReq, epc=0x3050 -> PC=0x3050, halted=0.
REQ-026 excReq and eretReq together with epc=0x3000 -> PC=0x4180; reset asserted with excReq -> PC=0x3000, BOOT.
REQ-027 With FETCH_ADEL_CHECK_EN: npc=0x3002 -> adel=1, excCode=4, pcValid=0, fetchCnt held; excReq next -> PC=0x4180, adel=0. Without macro, same stimulus -> adel=0, excCode=0.

Source files
------------

// File: rtl/fetch_pc.sv
// Fetch program counter with boot/run/halt sequencing and CP0 redirects.
// Optional fetch address checking is enabled by defining FETCH_ADEL_CHECK_EN.
module fetch_pc #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] HALT_PC   = 32'h0000_417C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] npc,
  input  logic        isBJ,
  input  logic        excReq,
  input  logic        eretReq,
  input  logic [31:0] epc,
  output logic [31:0] PC,
  output logic        pcValid,
  output logic        bd,
  output logic        halted,
  output logic        adel,
  output logic [4:0]  excCode,
  output logic [31:0] fetchCnt
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        bd_q, bd_d;

`ifdef FETCH_ADEL_CHECK_EN
  // Misaligned or outside user text/data window; BOOT never flags.
  assign adel    = (state_q != BOOT) &&
                   ((pc_q[1:0] != 2'b00) || (pc_q < 32'h0000_3000) || (pc_q > 32'h0000_6FFC));
  assign excCode = adel ? 5'd4 : 5'd0;
`else
  assign adel    = 1'b0;
  assign excCode = 5'd0;
`endif

  assign PC       = pc_q;
  assign bd       = bd_q;
  assign fetchCnt = cnt_q;
  assign halted   = (state_q == HALT);
  assign pcValid  = (state_q != BOOT) && !adel;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bd_d    = bd_q;
    cnt_d   = cnt_q;
    if (state_q == BOOT) begin
      state_d = RUN;
    end else begin
      if (pcValid && !stall && (state_q != HALT)) begin
        cnt_d = cnt_q + 32'd1;
      end
      // Redirects win over stall and halt so the handler can always be entered.
      if (excReq) begin
        pc_d    = EXC_ENTRY;
        bd_d    = 1'b0;
        state_d = RUN;
      end else if (eretReq) begin
        pc_d    = epc;
        bd_d    = 1'b0;
        state_d = RUN;
      end else if (stall || (state_q == HALT)) begin
        pc_d = pc_q;
      end else if (pc_q == HALT_PC) begin
        state_d = HALT;
      end else begin
        pc_d = npc;
        bd_d = isBJ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      bd_q    <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bd_q    <= bd_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc.sv
// Directed plus randomized bench for fetch_pc against a behavioural fetch model.
module tb_fetch_pc;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] HALT_PC   = 32'h0000_417C;

  logic        clk;
  logic        reset, stall, isBJ, excReq, eretReq;
  logic [31:0] npc, epc;
  logic [31:0] pcOut, fetchCnt;
  logic        pcValid, bd, halted, adel;
  logic [4:0]  excCode;

  int total = 0;
  int bad   = 0;

  // Behavioural model: "booting" means the single idle cycle after reset.
  bit          mBoot;
  bit          mHalt;
  logic [31:0] mPc;
  bit          mBd;
  logic [31:0] mCnt;

  fetch_pc #(.RESET_PC(RESET_PC), .EXC_ENTRY(EXC_ENTRY), .HALT_PC(HALT_PC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .npc(npc), .isBJ(isBJ),
    .excReq(excReq), .eretReq(eretReq), .epc(epc),
    .PC(pcOut), .pcValid(pcValid), .bd(bd), .halted(halted),
    .adel(adel), .excCode(excCode), .fetchCnt(fetchCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit modelAdel(input bit boot, input logic [31:0] a);
`ifdef FETCH_ADEL_CHECK_EN
    return !boot && ((a % 4) != 0 || a < 32'h3000 || a > 32'h6FFC);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    bit a;
    a = modelAdel(mBoot, mPc);
    chk({tag, ".PC"}, pcOut, mPc);
    chk({tag, ".pcValid"}, {31'd0, pcValid}, {31'd0, !mBoot && !a});
    chk({tag, ".bd"}, {31'd0, bd}, {31'd0, mBd});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, mHalt});
    chk({tag, ".adel"}, {31'd0, adel}, {31'd0, a});
    chk({tag, ".excCode"}, {27'd0, excCode}, a ? 32'd4 : 32'd0);
    chk({tag, ".fetchCnt"}, fetchCnt, mCnt);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic applyStimulus(input string tag, input bit r, input bit st, input bit bj,
                               input bit ex, input bit er, input logic [31:0] n,
                               input logic [31:0] e);
    bit          nBoot, nHalt, nBd;
    logic [31:0] nPc, nCnt;
    reset = r; stall = st; isBJ = bj; excReq = ex; eretReq = er; npc = n; epc = e;
    nBoot = mBoot; nHalt = mHalt; nPc = mPc; nBd = mBd; nCnt = mCnt;
    if (r) begin
      nBoot = 1; nHalt = 0; nPc = RESET_PC; nBd = 0; nCnt = 0;
    end else if (mBoot) begin
      nBoot = 0;
    end else begin
      if (!st && !mHalt && !modelAdel(mBoot, mPc)) nCnt = mCnt + 1;
      if (ex) begin
        nPc = EXC_ENTRY; nBd = 0; nHalt = 0;
      end else if (er) begin
        nPc = e; nBd = 0; nHalt = 0;
      end else if (st || mHalt) begin
        nPc = mPc;
      end else if (mPc == HALT_PC) begin
        nHalt = 1;
      end else begin
        nPc = n; nBd = bj;
      end
    end
    @(posedge clk);
    #1;
    mBoot = nBoot; mHalt = nHalt; mPc = nPc; mBd = nBd; mCnt = nCnt;
    checkOutput(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 0, 0, 0, 0, 0, mPc + 32'd4, 32'd0);
  endtask

  initial begin
    logic [31:0] rn, re;
    int guard;
    mBoot = 1; mHalt = 0; mPc = RESET_PC; mBd = 0; mCnt = 0;
    reset = 1; stall = 0; isBJ = 0; excReq = 0; eretReq = 0; npc = 0; epc = 0;

    applyStimulus("reset", 1, 0, 0, 0, 0, 32'd0, 32'd0);
    chk("bootPc", pcOut, 32'h3000);
    chk("bootValid", {31'd0, pcValid}, 32'd0);
    idle("run0");
    chk("run0Pc", pcOut, 32'h3000);
    chk("run0Cnt", fetchCnt, 32'd0);
    idle("run1");
    chk("run1Pc", pcOut, 32'h3004);
    chk("run1Cnt", fetchCnt, 32'd1);
    idle("run2");
    chk("run2Pc", pcOut, 32'h3008);

    guard = 0;
    while (mPc != 32'h3010 && guard < 20) begin
      idle("toBranch");
      guard++;
    end
    chk("reach3010", pcOut, 32'h3010);
    applyStimulus("branch", 0, 0, 1, 0, 0, 32'h3040, 32'd0);
    chk("branchPc", pcOut, 32'h3040);
    chk("branchBd", {31'd0, bd}, 32'd1);
    applyStimulus("slot", 0, 0, 0, 0, 0, 32'h3044, 32'd0);
    chk("slotBd", {31'd0, bd}, 32'd0);

    applyStimulus("toStall", 0, 0, 0, 0, 1, 32'h0, 32'h3020);
    for (int i = 0; i < 3; i++) applyStimulus("stall", 0, 1, 1, 0, 0, 32'h5000, 32'd0);
    chk("stallPc", pcOut, 32'h3020);
    applyStimulus("excInStall", 0, 1, 0, 1, 0, 32'h5000, 32'd0);
    chk("excPc", pcOut, 32'h4180);

    applyStimulus("toHaltPc", 0, 0, 0, 0, 0, 32'h417C, 32'd0);
    applyStimulus("haltEnter", 0, 0, 0, 0, 0, 32'h4180, 32'd0);
    chk("haltFlag", {31'd0, halted}, 32'd1);
    chk("haltPc", pcOut, 32'h417C);
    applyStimulus("haltHold", 0, 0, 0, 0, 0, 32'h4180, 32'd0);
    applyStimulus("eretHalt", 0, 0, 0, 0, 1, 32'h4180, 32'h3050);
    chk("eretPc", pcOut, 32'h3050);

    applyStimulus("excEret", 0, 0, 0, 1, 1, 32'h3054, 32'h3000);
    chk("excEretPc", pcOut, 32'h4180);
    applyStimulus("resetExc", 1, 0, 0, 1, 0, 32'h4184, 32'd0);
    chk("resetExcPc", pcOut, 32'h3000);
    idle("postReset");

    applyStimulus("misalign", 0, 0, 0, 0, 0, 32'h3002, 32'd0);
    applyStimulus("adelHold", 0, 0, 0, 0, 0, 32'h3002, 32'd0);
    applyStimulus("adelExc", 0, 0, 0, 1, 0, 32'h3006, 32'd0);
    chk("adelExcPc", pcOut, 32'h4180);

    for (int i = 0; i < 300; i++) begin
      rn = 32'h3000 + ($urandom_range(0, 4095) << 2);
      re = 32'h3000 + ($urandom_range(0, 4095) << 2);
      case ($urandom_range(0, 9))
        0: rn = HALT_PC;
        1: rn = rn | 32'd2;
        2: rn = 32'h8000;
        default: ;
      endcase
      applyStimulus("rand", $urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 19) == 0, rn, re);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
